// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_mode_t;

  function automatic parity_mode_t parity_mode(input logic en, input logic odd);
    if (!en) return PAR_NONE;
    return odd ? PAR_ODD : PAR_EVEN;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pad; both flops reset to the idle level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver: DBIT data bits, runtime parity and 1/2 stop bits.
// Define UART_RX_SYNC_EN to put a 2-flop synchroniser on rx ahead of the FSM.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  input  logic            s_tick,
  input  logic            par_en,
  input  logic            par_odd,
  input  logic            stop2,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic rx_i;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_i)
  );
`else
  assign rx_i = rx;
`endif

  rx_state_t       state, state_next;
  logic [SW-1:0]   s_reg, s_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  parity_mode_t    mode_reg, mode_next;
  logic            stop2_reg, stop2_next;
  logic            perr_reg, perr_next;
  logic            ferr_reg, ferr_next;
  logic            pbit_reg, pbit_next;
  logic            done_next;
  logic [DBIT-1:0] dout_next;
  logic            pe_next, fe_next, bk_next;
  logic            ferr_now;
  logic [NW-1:0]   stop_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      s_reg        <= '0;
      n_reg        <= '0;
      b_reg        <= '0;
      mode_reg     <= PAR_NONE;
      stop2_reg    <= 1'b0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
      pbit_reg     <= 1'b0;
      rx_done_tick <= 1'b0;
      dout         <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      state        <= state_next;
      s_reg        <= s_next;
      n_reg        <= n_next;
      b_reg        <= b_next;
      mode_reg     <= mode_next;
      stop2_reg    <= stop2_next;
      perr_reg     <= perr_next;
      ferr_reg     <= ferr_next;
      pbit_reg     <= pbit_next;
      rx_done_tick <= done_next;
      dout         <= dout_next;
      parity_err   <= pe_next;
      frame_err    <= fe_next;
      break_det    <= bk_next;
    end
  end

  // Stop bits reuse the bit counter: last stop sample is index 0 or 1.
  assign stop_last = stop2_reg ? NW'(1) : '0;

  always_comb begin
    state_next = state;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    mode_next  = mode_reg;
    stop2_next = stop2_reg;
    perr_next  = perr_reg;
    ferr_next  = ferr_reg;
    pbit_next  = pbit_reg;
    done_next  = 1'b0;
    dout_next  = dout;
    pe_next    = parity_err;
    fe_next    = frame_err;
    bk_next    = break_det;
    ferr_now   = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rx_i) begin
          state_next = START;
          s_next     = '0;
          mode_next  = parity_mode(par_en, par_odd);
          stop2_next = stop2;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_reg == S_MID) begin
            if (rx_i) begin
              state_next = IDLE;
            end else begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
              perr_next  = 1'b0;
              ferr_next  = 1'b0;
              pbit_next  = 1'b0;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_reg == S_END) begin
            s_next = '0;
            b_next = {rx_i, b_reg[DBIT-1:1]};
            if (n_reg == N_LAST) begin
              n_next     = '0;
              state_next = (mode_reg != PAR_NONE) ? PARITY : STOP;
            end else begin
              n_next = n_reg + 1'b1;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end

      PARITY: begin
        if (s_tick) begin
          if (s_reg == S_END) begin
            s_next     = '0;
            pbit_next  = rx_i;
            perr_next  = (^b_reg) ^ rx_i ^ (mode_reg == PAR_ODD);
            state_next = STOP;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s_reg == S_END) begin
            s_next    = '0;
            ferr_now  = ferr_reg | ~rx_i;
            ferr_next = ferr_now;
            if (n_reg == stop_last) begin
              done_next  = 1'b1;
              dout_next  = b_reg;
              pe_next    = (mode_reg != PAR_NONE) & perr_reg;
              fe_next    = ferr_now;
              bk_next    = ferr_now & ~(|b_reg) & ((mode_reg == PAR_NONE) | ~pbit_reg);
              n_next     = '0;
              state_next = ferr_now ? WAIT_HIGH : IDLE;
            end else begin
              n_next = n_reg + 1'b1;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end

      // A held-low line must return high before a new start is accepted.
      WAIT_HIGH: begin
        if (rx_i) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised oversampling UART receiver, successor to the fixed 8N1 receiver. Adds:
- configurable data width;
- runtime parity (none/even/odd) and 1 or 2 stop bits;
- start-bit glitch rejection;
- parity, framing and break detection.

It sits between the pad-side rx line and the rx FIFO. It is paced by the shared baud generator's s_tick, which fires OVERSAMPLE times per bit.

Parameters:
DBIT, 8, data bits per frame, legal 5..9
OVERSAMPLE, 16, s_tick pulses per bit period, even, legal 8..32

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
rx  in  1  serial line, idle high
s_tick  in  1  one-clk oversample strobe from baud generator
par_en  in  1  1 = parity bit present after data
par_odd  in  1  1 = odd parity, 0 = even; ignored when par_en=0
stop2  in  1  1 = two stop bits, 0 = one
rx_done_tick  out  1  one-clk pulse, frame complete
dout  out  DBIT  received data, LSB received first
parity_err  out  1  parity mismatch in last frame
frame_err  out  1  a stop-bit sample was 0 in last frame
break_det  out  1  last frame was a line break

Behaviour:
Clock, reset and counters
- Reset (rst=1, clk independent): state IDLE, all counters 0, dout=0, all flags 0, rx_done_tick=0.
- Tick counter width is $clog2(OVERSAMPLE). Bit counter width is $clog2(DBIT).
- All counting advances only on clk edges where s_tick=1.

Config capture
- par_en, par_odd and stop2 are registered on the IDLE->START transition.
- Changes mid-frame have no effect on that frame.

States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
- IDLE: rx=0 -> START, tick count=0.
- START: at tick count OVERSAMPLE/2-1 (mid start bit), sample rx.
  - rx=1: glitch, -> IDLE; no pulse, flags unchanged.
  - rx=0: -> DATA, counters cleared.
- DATA: at tick count OVERSAMPLE-1, shift rx in at the MSB (shift right) and clear the tick count.
  - After DBIT samples: -> PARITY if par_en=1, else -> STOP.
- PARITY: at tick count OVERSAMPLE-1, compute perr = (XOR of data bits ^ rx ^ par_odd) != 0; -> STOP.
- STOP: sample rx at tick count OVERSAMPLE-1 of each stop bit (1 or 2 bits). Any 0 sample sets ferr.
  - On the last stop sample, in the same clk:
    - pulse rx_done_tick;
    - load dout;
    - load parity_err=perr (0 if par_en=0);
    - load frame_err=ferr;
    - load break_det = ferr AND all data bits 0 AND (par_en=0 OR parity sample 0).
  - Then -> WAIT_HIGH if ferr, else -> IDLE.
- WAIT_HIGH: stay until rx=1, then -> IDLE. A held break therefore yields exactly one frame report.

Outputs and latency
- dout and the three flags are registered and hold until the next rx_done_tick.
- Flags are never cleared by a glitch abort.
- rx_done_tick fires 1.5 bit periods (OVERSAMPLE*3/2 ticks) plus DBIT+par_en+stop2 bit periods after the falling start edge.

Boundary conditions
- A falling edge on rx during STOP, after the last sample, is ignored until IDLE is reached.
- s_tick coincident with the IDLE->START transition is not counted.
- Reset mid-frame aborts with no pulse.

Optional Feature:
UART_RX_SYNC_EN
- Defined: rx passes through a 2-flop synchroniser (flops reset to 1) before the FSM, adding 2 clk latency to all sampling.
- Undefined: rx drives the FSM directly. The integrator guarantees rx is already synchronous.

Decomposition:
- Package uart_pkg holds:
  - typedef enum for the rx states (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - typedef parity_mode_t {PAR_NONE, PAR_EVEN, PAR_ODD};
  - constant DEFAULT_OVERSAMPLE=16.
- One sub-module: uart_rx_sync, a 2-flop synchroniser, instantiated only under UART_RX_SYNC_EN.

Test Plan:
All scenarios use DBIT=8, OVERSAMPLE=16 and 1 clk s_tick every 10 clk.
1. 8N1 byte 0xA5 -> one rx_done_tick, dout=0xA5, all flags 0.
2. Even parity, byte 0x37 with parity bit 1 -> dout=0x37, parity_err=0. Repeat with parity bit 0 -> parity_err=1, dout=0x37.
3. stop2=1, byte 0x3C, second stop bit driven 0 -> frame_err=1, break_det=0, done at second stop sample. FSM waits in WAIT_HIGH until rx=1, then accepts next byte 0x81 with frame_err=0.
4. rx held low for 20 bit times -> exactly one done, with dout=0x00, frame_err=1, break_det=1. No further done until rx returns high and a new frame starts.
5. rx low for 4 s_ticks then high -> no rx_done_tick; previous dout and flags unchanged.
6. rst asserted mid-DATA of byte 0xFF -> all outputs 0 immediately. Next frame 0x5A is received correctly with no flags set.
